lt24_ctrl_pio: RTL and testbench
================================

LT24_CTRL_PIO -- requirements
Module: lt24_ctrl_pio

Interface
REQ-001 SHALL have parameter WIDTH, default 1, meaning output port width (legal range 1..32).
REQ-002 SHALL have parameter RESET_VALUE, default 0, meaning the DATA register value after reset, truncated to WIDTH.
REQ-003 SHALL have parameter PULSE_W, default 16, meaning the pulse-length counter width (legal range 1..32).
REQ-004 SHALL have the following ports: clk  in  1  single clock, all logic on the rising edge.
REQ-005 SHALL have the following port: reset_n  in  1  reset, synchronous and active-low.
REQ-006 SHALL have port address  in  3  register select.
REQ-007 SHALL have port chipselect  in  1  slave select.
REQ-008 SHALL have port write_n  in  1  write strobe, active-low.
REQ-009 SHALL have port writedata  in  32  write data.
REQ-010 SHALL have port readdata  out  32  read data, combinational from address.
REQ-011 SHALL have port out_port  out  WIDTH  driven pins.

Function
REQ-012 SHALL qualify a write as chipselect=1, write_n=0 at a rising clk edge; all register effects SHALL be visible on out_port the following cycle (1-cycle latency).
REQ-013 SHALL implement register map: 0 DATA (RW), 1 SET (W), 2 CLEAR (W), 3 PULSE_LEN (RW), 4 PULSE_GO (W mask / R status).
REQ-014 SHALL load DATA <= writedata[WIDTH-1:0] on a write to address 0.
REQ-015 SHALL set DATA <= DATA | writedata[WIDTH-1:0] on a write to 1, and DATA <= DATA & ~writedata[WIDTH-1:0] on a write to 2.
REQ-016 SHALL load PULSE_LEN <= writedata[PULSE_W-1:0] on a write to 3.
REQ-017 SHALL, on a write to 4 while idle with PULSE_LEN != 0, latch MASK <= writedata[WIDTH-1:0], load the counter with PULSE_LEN, and enter BUSY.
REQ-018 SHALL use two states, IDLE and BUSY: IDLE->BUSY on an accepted PULSE_GO; BUSY decrements the counter each cycle; BUSY->IDLE on the cycle the counter equals 1.
REQ-019 SHALL drive out_port = DATA ^ (BUSY ? MASK : 0), so that the masked bits are inverted for exactly PULSE_LEN cycles.
REQ-020 SHALL ignore PULSE_GO writes while BUSY and when PULSE_LEN = 0, with no state change.
REQ-021 SHALL, while BUSY, still accept DATA/SET/CLEAR writes, and the pulse SHALL continue to invert the updated DATA.
REQ-022 SHALL, while BUSY, leave a PULSE_LEN write stored but not affecting the running count.
REQ-023 SHALL return on readdata, zero-extended: address 0 -> DATA; 3 -> PULSE_LEN; 4 -> bit0 = BUSY; 1, 2, 5-7 -> 0.
REQ-024 SHALL ignore writes to addresses 5-7.

Reset
REQ-025 SHALL, when reset_n=0 at a clk edge, set DATA=RESET_VALUE, PULSE_LEN=0, MASK=0, counter=0, and state=IDLE; out_port SHALL then equal RESET_VALUE.
REQ-026 SHALL abort any pulse in progress on reset, with no residual inversion after the reset edge.
REQ-027 SHALL have reset priority over any write in the same cycle.

Configuration
REQ-028 SHALL, with LT24_CTRL_PIO_PULSE_EN defined, include the pulse engine per REQ-016..REQ-022.
REQ-029 SHALL, without LT24_CTRL_PIO_PULSE_EN, omit the PULSE_LEN, MASK and counter state; writes to 3-4 SHALL be ignored, reads of 3-4 SHALL return 0, and out_port SHALL equal DATA.

Structure
REQ-030 SHALL define the register address constants (ADDR_DATA..ADDR_PULSE) and the state enum in shared package lt24_pio_pkg.
REQ-031 SHALL implement the counter and IDLE/BUSY FSM in sub-module lt24_pio_pulse_timer (inputs: start, len; outputs: busy), instantiated only when LT24_CTRL_PIO_PULSE_EN is defined.

Verification
REQ-032 SHALL cover: WIDTH=8, RESET_VALUE=8'hA5, reset -> out_port=8'hA5, readdata(addr0)=32'h0000_00A5.
REQ-033 SHALL cover: write DATA=8'h0F, SET 8'h30, CLEAR 8'h01 -> out_port sequence 0F, 3F, 3E, each one cycle after its write.
REQ-034 SHALL cover: PULSE_LEN=5, DATA=8'h00, PULSE_GO 8'h01 -> out_port=8'h01 for exactly 5 cycles and then 8'h00; addr4 reads 1 during the pulse and 0 after.
REQ-035 SHALL cover: a second PULSE_GO 8'hFF at cycle 2 of that pulse -> ignored, mask stays 8'h01, and the pulse still ends at cycle 5; PULSE_LEN=0 followed by GO -> no pulse.
REQ-036 SHALL cover: during a pulse with mask 8'h01, write DATA=8'h81 -> out_port=8'h80 until the pulse ends, then 8'h81.
REQ-037 SHALL cover: reset_n low at cycle 3 of a pulse -> out_port=RESET_VALUE on the next edge and BUSY=0.

Source files
------------

// File: rtl/lt24_pio_pkg.sv
// Shared definitions for the LT24 control PIO: register addresses and
// the pulse engine state encoding.
package lt24_pio_pkg;

  localparam logic [2:0] ADDR_DATA      = 3'd0;
  localparam logic [2:0] ADDR_SET       = 3'd1;
  localparam logic [2:0] ADDR_CLEAR     = 3'd2;
  localparam logic [2:0] ADDR_PULSE_LEN = 3'd3;
  localparam logic [2:0] ADDR_PULSE     = 3'd4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } pulse_state_t;

endpackage

// File: rtl/lt24_pio_pulse_timer.sv
// Pulse length timer for the LT24 control PIO.
// A start request is honoured only while idle and with a non-zero length;
// busy is then high for exactly len cycles.
module lt24_pio_pulse_timer
  import lt24_pio_pkg::*;
#(
  parameter int PULSE_W = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic [PULSE_W-1:0] len,
  output logic               busy
);

  pulse_state_t       r_state;
  logic [PULSE_W-1:0] r_count;
  logic               r_busy;

  // IDLE/BUSY state machine with down-counter; leaves BUSY when the count reaches 1
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_count <= '0;
      r_busy  <= 1'b0;
    end else if (r_state == ST_IDLE) begin
      if (start && (len != '0)) begin
        r_state <= ST_BUSY;
        r_count <= len;
        r_busy  <= 1'b1;
      end
    end else begin
      if (r_count == PULSE_W'(1)) begin
        r_state <= ST_IDLE;
        r_count <= '0;
        r_busy  <= 1'b0;
      end else begin
        r_count <= r_count - PULSE_W'(1);
      end
    end
  end

  assign busy = r_busy;

endmodule

// File: rtl/lt24_ctrl_pio.sv
// LT24 control PIO: output register with set/clear aliases and an
// optional timed inversion pulse engine.
// Optional feature macro: LT24_CTRL_PIO_PULSE_EN (pulse engine present).
module lt24_ctrl_pio
  import lt24_pio_pkg::*;
#(
  parameter int          WIDTH       = 1,
  parameter logic [31:0] RESET_VALUE = 32'd0,
  parameter int          PULSE_W     = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port
);

  localparam logic [WIDTH-1:0] LP_RESET = RESET_VALUE[WIDTH-1:0];

  logic             w_wr;
  logic [WIDTH-1:0] w_wdata;
  logic [WIDTH-1:0] r_data;
  logic             w_unusedWdata;

  assign w_wr          = chipselect && !write_n;
  assign w_wdata       = writedata[WIDTH-1:0];
  assign w_unusedWdata = ^writedata;

  // DATA register with direct load, bitwise set and bitwise clear
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_data <= LP_RESET;
    end else if (w_wr) begin
      case (address)
        ADDR_DATA:  r_data <= w_wdata;
        ADDR_SET:   r_data <= r_data | w_wdata;
        ADDR_CLEAR: r_data <= r_data & ~w_wdata;
        default:    r_data <= r_data;
      endcase
    end
  end

`ifdef LT24_CTRL_PIO_PULSE_EN
  logic [PULSE_W-1:0] r_pulseLen;
  logic [WIDTH-1:0]   r_mask;
  logic               w_go;
  logic               w_busy;

  assign w_go = w_wr && (address == ADDR_PULSE);

  // Pulse length register; a rewrite during a pulse only affects the next one
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_pulseLen <= '0;
    end else if (w_wr && (address == ADDR_PULSE_LEN)) begin
      r_pulseLen <= writedata[PULSE_W-1:0];
    end
  end

  // Inversion mask, captured only when the timer will accept the start
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_mask <= '0;
    end else if (w_go && !w_busy && (r_pulseLen != '0)) begin
      r_mask <= w_wdata;
    end
  end

  lt24_pio_pulse_timer #(
    .PULSE_W (PULSE_W)
  ) u_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (w_go),
    .len     (r_pulseLen),
    .busy    (w_busy)
  );

  assign out_port = r_data ^ (w_busy ? r_mask : '0);

  // Register readback, zero-extended to the bus width
  always_comb begin
    readdata = '0;
    case (address)
      ADDR_DATA:      readdata[WIDTH-1:0]   = r_data;
      ADDR_PULSE_LEN: readdata[PULSE_W-1:0] = r_pulseLen;
      ADDR_PULSE:     readdata[0]           = w_busy;
      default:        readdata              = '0;
    endcase
  end
`else
  logic [PULSE_W-1:0] w_unusedLen;

  assign w_unusedLen = '0;
  assign out_port    = r_data;

  // Register readback; only DATA is readable without the pulse engine
  always_comb begin
    readdata = '0;
    if (address == ADDR_DATA) begin
      readdata[WIDTH-1:0] = r_data;
    end
  end
`endif

endmodule

// File: tb/tb_lt24_ctrl_pio.sv
// Self-checking bench for lt24_ctrl_pio (WIDTH=8, RESET_VALUE=8'hA5).
// Pulse sequences are exercised when LT24_CTRL_PIO_PULSE_EN is defined.
module tb_lt24_ctrl_pio;
  import lt24_pio_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [2:0]  address = 3'd0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = 32'd0;
  logic [31:0] readdata;
  logic [7:0]  out_port;

  int nChecks = 0;
  int nErrors = 0;

  typedef struct {
    string      name;
    logic [7:0] value;
  } expItem_t;

  expItem_t expQ[$];

  typedef struct {
    logic        cs;
    logic        wrN;
    logic [2:0]  addr;
    logic [31:0] data;
    logic [7:0]  expOut;
    logic [2:0]  rdAddr;
    logic [31:0] expRd;
  } vec_t;

  vec_t vecs[9];

  lt24_ctrl_pio #(
    .WIDTH       (8),
    .RESET_VALUE (32'h0000_00A5),
    .PULSE_W     (16)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .out_port   (out_port)
  );

  // Free-running 10-unit clock
  always #5 clk = ~clk;

  // Hard stop in case the sequence ever stalls
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    nChecks++;
    if (actual !== expected) begin
      nErrors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Drive one cycle of bus activity, then compare out_port after the edge
  task automatic applyStimulus(input logic rstN, input logic cs, input logic wrN,
                               input logic [2:0] addr, input logic [31:0] data,
                               input logic [7:0] expOut, input string name);
    expItem_t item;
    @(negedge clk);
    reset_n    = rstN;
    chipselect = cs;
    write_n    = wrN;
    address    = addr;
    writedata  = data;
    item.name  = name;
    item.value = expOut;
    expQ.push_back(item);
    @(posedge clk);
    #1;
    reset_n    = 1'b1;
    chipselect = 1'b0;
    write_n    = 1'b1;
    item = expQ.pop_front();
    checkOutput(item.name, {24'h0, out_port}, {24'h0, item.value});
  endtask

  task automatic writeReg(input logic [2:0] addr, input logic [31:0] data,
                          input logic [7:0] expOut, input string name);
    applyStimulus(1'b1, 1'b1, 1'b0, addr, data, expOut, name);
  endtask

  task automatic idleCycle(input logic [7:0] expOut, input string name);
    applyStimulus(1'b1, 1'b0, 1'b1, 3'd0, 32'd0, expOut, name);
  endtask

  task automatic readCheck(input logic [2:0] addr, input logic [31:0] expected,
                           input string name);
    address = addr;
    #1;
    checkOutput(name, readdata, expected);
  endtask

  // Main test sequence
  initial begin
    vecs[0] = '{1'b1, 1'b0, 3'd0, 32'h0000_000F, 8'h0F, 3'd0, 32'h0000_000F};
    vecs[1] = '{1'b1, 1'b0, 3'd1, 32'h0000_0030, 8'h3F, 3'd1, 32'h0000_0000};
    vecs[2] = '{1'b1, 1'b0, 3'd2, 32'h0000_0001, 8'h3E, 3'd2, 32'h0000_0000};
    vecs[3] = '{1'b1, 1'b0, 3'd5, 32'h0000_00FF, 8'h3E, 3'd5, 32'h0000_0000};
    vecs[4] = '{1'b1, 1'b0, 3'd7, 32'h0000_0000, 8'h3E, 3'd0, 32'h0000_003E};
    vecs[5] = '{1'b0, 1'b0, 3'd0, 32'h0000_0000, 8'h3E, 3'd6, 32'h0000_0000};
    vecs[6] = '{1'b1, 1'b1, 3'd0, 32'h0000_0000, 8'h3E, 3'd0, 32'h0000_003E};
    vecs[7] = '{1'b1, 1'b0, 3'd0, 32'h1234_5600, 8'h00, 3'd0, 32'h0000_0000};
    vecs[8] = '{1'b1, 1'b0, 3'd1, 32'hFFFF_FF81, 8'h81, 3'd0, 32'h0000_0081};

    applyStimulus(1'b0, 1'b0, 1'b1, 3'd0, 32'd0, 8'hA5, "reset c1");
    applyStimulus(1'b0, 1'b0, 1'b1, 3'd0, 32'd0, 8'hA5, "reset c2");
    readCheck(3'd0, 32'h0000_00A5, "reset rd data");
    readCheck(3'd3, 32'h0000_0000, "reset rd len");
    readCheck(3'd4, 32'h0000_0000, "reset rd busy");

    for (int i = 0; i < 9; i++) begin
      applyStimulus(1'b1, vecs[i].cs, vecs[i].wrN, vecs[i].addr, vecs[i].data,
                    vecs[i].expOut, $sformatf("vec%0d out", i));
      readCheck(vecs[i].rdAddr, vecs[i].expRd, $sformatf("vec%0d rd", i));
    end

`ifdef LT24_CTRL_PIO_PULSE_EN
    writeReg(3'd3, 32'hABCD_0005, 8'h81, "len5 write");
    readCheck(3'd3, 32'h0000_0005, "len5 rd");
    writeReg(3'd0, 32'h0000_0000, 8'h00, "data00");

    writeReg(3'd4, 32'h0000_0001, 8'h01, "pulseA c1");
    readCheck(3'd4, 32'h0000_0001, "pulseA busy c1");
    for (int k = 2; k <= 5; k++) begin
      idleCycle(8'h01, $sformatf("pulseA c%0d", k));
    end
    readCheck(3'd4, 32'h0000_0001, "pulseA busy c5");
    idleCycle(8'h00, "pulseA end");
    readCheck(3'd4, 32'h0000_0000, "pulseA busy end");

    writeReg(3'd4, 32'h0000_0001, 8'h01, "pulseB c1");
    writeReg(3'd4, 32'h0000_00FF, 8'h01, "pulseB rego c2");
    readCheck(3'd4, 32'h0000_0001, "pulseB busy c2");
    for (int k = 3; k <= 5; k++) begin
      idleCycle(8'h01, $sformatf("pulseB c%0d", k));
    end
    idleCycle(8'h00, "pulseB end");

    writeReg(3'd4, 32'h0000_0001, 8'h01, "pulseC c1");
    writeReg(3'd0, 32'h0000_0081, 8'h80, "pulseC data81");
    writeReg(3'd3, 32'h0000_0002, 8'h80, "pulseC len2");
    readCheck(3'd3, 32'h0000_0002, "pulseC rd len2");
    idleCycle(8'h80, "pulseC c4");
    idleCycle(8'h80, "pulseC c5");
    idleCycle(8'h81, "pulseC end");
    readCheck(3'd4, 32'h0000_0000, "pulseC busy end");

    writeReg(3'd4, 32'h0000_0002, 8'h83, "len2 c1");
    idleCycle(8'h83, "len2 c2");
    idleCycle(8'h81, "len2 end");

    writeReg(3'd3, 32'h0000_0000, 8'h81, "len0 write");
    writeReg(3'd4, 32'h0000_00FF, 8'h81, "len0 go");
    readCheck(3'd4, 32'h0000_0000, "len0 busy");
    idleCycle(8'h81, "len0 after");

    writeReg(3'd3, 32'h0000_0005, 8'h81, "pulseD len5");
    writeReg(3'd0, 32'h0000_0000, 8'h00, "pulseD data00");
    writeReg(3'd4, 32'h0000_0001, 8'h01, "pulseD c1");
    idleCycle(8'h01, "pulseD c2");
    applyStimulus(1'b0, 1'b1, 1'b0, 3'd0, 32'h0000_00FF, 8'hA5, "pulseD reset");
    readCheck(3'd4, 32'h0000_0000, "pulseD busy");
    readCheck(3'd0, 32'h0000_00A5, "pulseD rd data");
    readCheck(3'd3, 32'h0000_0000, "pulseD rd len");
    idleCycle(8'hA5, "pulseD post1");
    idleCycle(8'hA5, "pulseD post2");
    writeReg(3'd4, 32'h0000_00FF, 8'hA5, "pulseD go len0");
`else
    writeReg(3'd3, 32'h0000_0005, 8'h81, "nopulse len write");
    readCheck(3'd3, 32'h0000_0000, "nopulse rd len");
    writeReg(3'd4, 32'h0000_00FF, 8'h81, "nopulse go");
    readCheck(3'd4, 32'h0000_0000, "nopulse rd busy");
    idleCycle(8'h81, "nopulse after");
    applyStimulus(1'b0, 1'b1, 1'b0, 3'd0, 32'h0000_00FF, 8'hA5, "reset over write");
    readCheck(3'd0, 32'h0000_00A5, "reset over write rd");
`endif

    $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
    $finish;
  end

endmodule
